// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_pkg
// Brief    : Default parameters and burst FSM state encoding for arb_dram.
// Revision : 1.0 - initial release
// ============================================================================
package dram_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } dram_state_e;

endpackage
`default_nettype wire

// File: rtl/arb_dram_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_dram_if
// Brief    : Request/grant/read-return bundle shared by requesters and arb_dram.
//            Burst lane exists only when DRAM_BURST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface arb_dram_if
  import dram_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [NUM_CH-1:0]        Req;
  logic [NUM_CH-1:0]        WR;
  logic [NUM_CH*ADDR_W-1:0] Addr;
  logic [NUM_CH*DATA_W-1:0] DataIn;
`ifdef DRAM_BURST_EN
  logic [NUM_CH-1:0]        Burst;
`endif
  logic [NUM_CH-1:0]        Gnt;
  logic [NUM_CH-1:0]        RdValid;
  logic [DATA_W-1:0]        DataOut;
  logic                     Busy;

  modport master (
`ifdef DRAM_BURST_EN
    output Burst,
`endif
    output Req, WR, Addr, DataIn,
    input  Gnt, RdValid, DataOut, Busy
  );

  modport slave (
`ifdef DRAM_BURST_EN
    input  Burst,
`endif
    input  Req, WR, Addr, DataIn,
    output Gnt, RdValid, DataOut, Busy
  );

endinterface
`default_nettype wire

// File: rtl/arb_dram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin one-hot arbiter; search starts at channel ptr and wraps.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx
);

  logic found;

  // Two passes avoid a modulo: channels at/above ptr first, then the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
        found   = 1'b1;
      end
    end
    if (!en) begin
      gnt     = '0;
      gnt_idx = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_dram.sv
`default_nettype none
// ============================================================================
// Module   : arb_dram
// Brief    : Multi-channel round-robin arbitrated memory with pipelined reads.
//            Optional burst reads enabled by macro DRAM_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb_dram
  import dram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic      Clk,
  input  logic      Reset,
  arb_dram_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              busy;
  logic              arb_en;
  logic              acc;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [IDX_W-1:0]  acc_idx;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NUM_CH-1:0] issue_v;
  logic [IDX_W-1:0]  issue_idx;
  logic [NUM_CH-1:0] pipe_v_q [RD_LAT];
  logic [NUM_CH-1:0] pipe_v_d [RD_LAT];
  logic [DATA_W-1:0] pipe_d_q [RD_LAT];
  logic [DATA_W-1:0] pipe_d_d [RD_LAT];
  logic [NUM_CH-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

`ifdef DRAM_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN);

  logic              sel_burst;
  dram_state_e       state_q, state_d;
  logic [IDX_W-1:0]  burst_idx_q, burst_idx_d;
  logic [NUM_CH-1:0] burst_ch_q, burst_ch_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
`endif

  assign arb_en = !Reset && !busy;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .en      (arb_en),
    .req     (bus.Req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
`ifdef DRAM_BURST_EN
    sel_burst = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_wr   = bus.WR[i];
        sel_addr = bus.Addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.DataIn[i*DATA_W +: DATA_W];
`ifdef DRAM_BURST_EN
        sel_burst = bus.Burst[i];
`endif
      end
    end
  end

  // Upper address bits are deliberately dropped so the index wraps mod DEPTH.
  assign acc              = |gnt;
  assign acc_idx          = sel_addr[IDX_W-1:0];
  assign unused_addr_bits = ^sel_addr;

  always_comb begin
    ptr_d = ptr_q;
    if (acc) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (acc && sel_wr) begin
      mem_q[acc_idx] <= sel_data;
    end
  end

`ifdef DRAM_BURST_EN
  assign busy = (state_q == BURST);

  always_comb begin
    state_d     = state_q;
    burst_idx_d = burst_idx_q;
    burst_ch_d  = burst_ch_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc && !sel_wr && sel_burst) begin
          state_d     = BURST;
          burst_idx_d = acc_idx + IDX_W'(1);
          burst_ch_d  = gnt;
          burst_cnt_d = CNT_W'(BURST_LEN - 1);
        end
      end
      BURST: begin
        burst_idx_d = burst_idx_q + IDX_W'(1);
        burst_cnt_d = burst_cnt_q - CNT_W'(1);
        if (burst_cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      burst_idx_q <= '0;
      burst_ch_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_idx_q <= burst_idx_d;
      burst_ch_q  <= burst_ch_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Read data is sampled at issue so later writes cannot alter an in-flight read.
  always_comb begin
    issue_v   = (acc && !sel_wr) ? gnt : '0;
    issue_idx = acc_idx;
`ifdef DRAM_BURST_EN
    if (busy) begin
      issue_v   = burst_ch_q;
      issue_idx = burst_idx_q;
    end
`endif
    pipe_v_d[0] = issue_v;
    pipe_d_d[0] = mem_q[issue_idx];
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_v_d[s] = pipe_v_q[s-1];
      pipe_d_d[s] = pipe_d_q[s-1];
    end
    rd_valid_d = pipe_v_q[RD_LAT-1];
    data_out_d = (|pipe_v_q[RD_LAT-1]) ? pipe_d_q[RD_LAT-1] : data_out_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
      data_out_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v_q[s] <= '0;
        pipe_d_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v_q[s] <= pipe_v_d[s];
        pipe_d_q[s] <= pipe_d_d[s];
      end
    end
  end

  assign bus.Gnt     = gnt;
  assign bus.RdValid = Reset ? '0 : rd_valid_q;
  assign bus.DataOut = Reset ? '0 : data_out_q;
  assign bus.Busy    = busy && !Reset;

endmodule
`default_nettype wire

// File: doc/arb_dram.md
ARB_DRAM -- requirements
Module: arb_dram

Interface
- REQ-001 Parameter DATA_W, 16, word width in bits.
- REQ-002 Parameter ADDR_W, 16, request address width in bits.
- REQ-003 Parameter DEPTH, 1024, words of storage; SHALL be a power of two and no greater than 2**ADDR_W.
- REQ-004 Parameter NUM_CH, 2, number of requester channels; SHALL be at least 1.
- REQ-005 Parameter RD_LAT, 2, read latency in cycles; SHALL be at least 1.
- REQ-006 Parameter BURST_LEN, 4, beats per burst read; SHALL be at least 2; used only with the burst macro.
- REQ-007 Port Clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
- REQ-008 Port Reset, input, 1 bit: reset, synchronous and active-high.
- REQ-009 Port Req, input, NUM_CH bits: per-channel request.
- REQ-010 Port WR, input, NUM_CH bits: per-channel write enable; 1 = write, 0 = read.
- REQ-011 Port Addr, input, NUM_CH*ADDR_W bits: per-channel addresses; channel i occupies slice i.
- REQ-012 Port DataIn, input, NUM_CH*DATA_W bits: per-channel write data; channel i occupies slice i.
- REQ-013 Port Burst, input, NUM_CH bits: per-channel burst-read request; present only with DRAM_BURST_EN.
- REQ-014 Port Gnt, output, NUM_CH bits: one-hot grant; combinational from Req and the arbiter state.
- REQ-015 Port RdValid, output, NUM_CH bits: DataOut belongs to channel i when bit i is set.
- REQ-016 Port DataOut, output, DATA_W bits: read data, registered.
- REQ-017 Port Busy, output, 1 bit: a burst is in progress.

Function
- REQ-018 A request SHALL be accepted on the rising edge where Req[i] and Gnt[i] are both 1; a channel SHALL hold Req, WR, Addr and DataIn stable until it is accepted.
- REQ-019 At most one Gnt bit SHALL be set per cycle; Gnt SHALL be all zero when Req is zero or Busy is 1.
- REQ-020 Arbitration SHALL be round-robin: search starts at pointer P; after an accept, P becomes (granted channel + 1) mod NUM_CH; P is unchanged on idle cycles.
- REQ-021 The storage index SHALL be Addr mod DEPTH; higher address bits are ignored and the index wraps.
- REQ-022 An accepted write SHALL update memory on the accept edge; RdValid SHALL NOT be raised for a write.
- REQ-023 An accepted read SHALL present data with RdValid[i] = 1 for exactly one cycle, RD_LAT cycles after the accept edge; the read pipeline SHALL accept one request per cycle.
- REQ-024 A read accepted the cycle after a write to the same address SHALL return the newly written data.
- REQ-025 DataOut SHALL hold its last value while RdValid is zero.

Reset
- REQ-026 While Reset is high, the block SHALL drive Gnt = 0, RdValid = 0, DataOut = 0 and Busy = 0, set P to 0, and put the FSM in IDLE.
- REQ-027 Reset SHALL flush all in-flight reads and any active burst, so no RdValid is raised for them afterwards.
- REQ-028 Reset SHALL leave memory contents unchanged.

Configuration
- REQ-029 Macro DRAM_BURST_EN defined: the FSM SHALL have states IDLE and BURST.
  - An accepted read with Burst[i] = 1 moves the FSM IDLE -> BURST.
  - The FSM issues internal reads at A+1 through A+BURST_LEN-1, one per cycle, each wrapped mod DEPTH.
  - Busy = 1 during those BURST_LEN-1 cycles; the FSM then returns to IDLE.
  - The channel sees BURST_LEN consecutive RdValid cycles starting RD_LAT cycles after accept.
  - Burst with WR = 1 SHALL be treated as a single write.
- REQ-030 Macro DRAM_BURST_EN undefined: the Burst port, Busy logic and FSM SHALL be absent, and Busy SHALL be tied to 0.

Structure
- REQ-031 Package dram_pkg SHALL hold the default parameter constants and the FSM state enum (IDLE, BURST).
- REQ-032 Sub-module rr_arbiter (NUM_CH-wide request, pointer, one-hot grant) SHALL hold the round-robin logic.

Verification
- REQ-033 Reset, then ch0 writes 0xBEEF to address 5 and the next cycle reads address 5 -> RdValid[0] = 1 exactly 2 cycles after the read accept, DataOut = 0xBEEF.
- REQ-034 Both channels read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1.
- REQ-035 With DEPTH = 1024, write 0x1234 to address 0x0403, then read address 0x0003 -> DataOut = 0x1234.
- REQ-036 DRAM_BURST_EN defined, memory[1022..1023,0..1] = 1,2,3,4, burst read at address 1022 -> four consecutive RdValid[0] with data 1,2,3,4; Busy high for 3 cycles; Gnt[1] = 0 during the burst.
- REQ-037 Reset asserted 1 cycle after a read accept -> RdValid stays 0 and DataOut = 0; memory is unchanged on a later read.
- REQ-038 Req = 0 for 10 cycles -> Gnt = 0, RdValid = 0, P unchanged.
